nr_div_seq: RTL and testbench
=============================

// Module: nr_div_seq
// PURPOSE
//  Sequential radix-2 non-restoring divider; the inverse-operation companion to the Booth multiplier datapath.
//  Shares its operand protocol: a start rising edge, then dividend and divisor presented serially on one data_in bus.
//  Produces quotient and remainder after a fixed latency, then pulses done.
//  Sits beside the multiplier in the arithmetic unit and is driven by the same operand sequencer.
// PARAMETERS
//  WIDTH   8   operand, quotient and remainder width in bits (>=4)
// PORTS
//  clk         in   1      single clock; all state updates on the rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      operation request; only its rising edge counts
//  data_in     in   WIDTH  operand bus: dividend, then divisor on consecutive cycles
//  quotient    out  WIDTH  registered quotient
//  remainder   out  WIDTH  registered remainder
//  busy        out  1      high from the start-edge capture until the done pulse
//  done        out  1      one-cycle pulse when the outputs update
//  div_by_zero out  1      registered flag; holds until the next completion
//  overflow    out  1      registered flag; holds until the next completion
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, cycle counter 0, start_d=0. Applies at any time, including mid-CALC.
//  Trigger: start_rise = start & ~start_d, with start_d registered every cycle.
//   Holding start high produces exactly one operation.
//   A start_rise seen outside IDLE is ignored.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> CALC -> FIX -> IDLE.
//   E0: start_rise in IDLE -> LOAD_A; busy=1.
//   E1 (LOAD_A): dividend <= data_in -> LOAD_B.
//   E2 (LOAD_B): divisor <= data_in.
//    If divisor==0 -> FIX with the dbz path.
//    Otherwise -> CALC with count=WIDTH-1.
//   CALC: one non-restoring step per cycle on magnitudes.
//    Partial remainder P is WIDTH+1 bits, signed.
//    Shift {P,Q} left 1. If P>=0 then P-=D, else P+=D. Q[0] = ~P[WIDTH].
//    Leave CALC after WIDTH steps (count==0).
//   FIX: if P<0 then P+=D. Apply sign correction. Register quotient, remainder and flags.
//    done=1 for exactly this following cycle; busy=0. -> IDLE.
//  Latency: done is high in the cycle after edge E(3+WIDTH); for WIDTH=8 that is after E11.
//   The dbz path completes after E3.
//  quotient, remainder and flags hold their values until the next FIX; they are untouched by a new start.
//  Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
//  Arithmetic, signed mode: operands are two's complement.
//   Quotient truncates toward zero. Remainder takes the dividend's sign, |r|<|divisor|.
//   Negate quotient if the operand signs differ. Negate remainder if the dividend is negative.
//   Most-negative / -1 (8'h80/8'hFF): quotient=8'h80, remainder=0, overflow=1.
//  Arithmetic, unsigned mode: plain magnitudes; overflow is always 0.
//  data_in is sampled only on E1 and E2; values at other times have no effect.
// CONFIGURATION
//  DIV_SIGNED_EN defined: signed two's-complement division as above.
//   Adds the abs/negate logic and overflow detection.
//  DIV_SIGNED_EN undefined: unsigned division.
//   No sign correction; overflow is tied to 0.
//   Cycle latency is identical in both builds.
// TESTING
//  1. Unsigned or signed build: start edge, 100, 7 -> after E11: quotient=14, remainder=2, done for 1 cycle, flags 0.
//  2. DIV_SIGNED_EN: 8'hF6 (-10) / 3 -> quotient=8'hFD (-3), remainder=8'hFF (-1). Also 10 / 8'hFD -> quotient=8'hFD, remainder=1.
//  3. 10 / 0 -> after E3: quotient=8'hFF, remainder=8'h0A, div_by_zero=1, done pulse; busy low after the pulse.
//  4. DIV_SIGNED_EN: 8'h80 / 8'hFF -> quotient=8'h80, remainder=0, overflow=1.
//   Unsigned build: 128/255 -> quotient=0, remainder=128, overflow=0.
//  5. start held high for 40 cycles with operands 200, 9 -> exactly one done pulse; quotient=22, remainder=2. A second start edge mid-CALC is ignored.
//  6. rst_n pulsed low during CALC -> all outputs 0 immediately, no done. A new operation 255/16 then gives quotient=15, remainder=15.

Source files
------------

// File: rtl/nr_div_seq.sv
// -----------------------------------------------------------------------------
// nr_div_seq
//   Sequential radix-2 non-restoring divider. A rising edge on start opens an
//   operation. The dividend and then the divisor follow on data_in on
//   consecutive cycles. The divider then runs WIDTH iteration cycles and one
//   fix-up cycle. It registers quotient, remainder and flags, and pulses done
//   for one cycle.
//
//   Build option:
//     DIV_SIGNED_EN  defined   -> two's-complement operands. Quotient truncates
//                                 toward zero and the remainder takes the
//                                 dividend's sign. 8'h80 / 8'hFF gives overflow.
//                    undefined -> unsigned division. overflow is always 0.
//   The cycle latency is the same in both builds.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      operation request; only its rising edge counts
//   data_in      in   WIDTH  dividend (first cycle), then divisor (second cycle)
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   busy         out  1      high from start capture until the done pulse
//   done         out  1      one-cycle pulse when results update
//   div_by_zero  out  1      set by a divide by zero; held until next completion
//   overflow     out  1      signed most-negative / -1; held until next completion
// -----------------------------------------------------------------------------
module nr_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic             start_d_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;  // raw dividend, also the dbz remainder
    logic [WIDTH-1:0] d_q, d_d;                // divisor magnitude
    logic [WIDTH:0]   p_q, p_d;                // signed partial remainder
    logic [WIDTH-1:0] q_q, q_d;                // quotient magnitude / shifted dividend
    logic             neg_q_q, neg_q_d;        // negate quotient at fix-up
    logic             neg_r_q, neg_r_d;        // negate remainder at fix-up
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic             start_rise;
    logic             a_neg, b_neg, ovf_det;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   p_sh, p_step, p_fix;

    assign start_rise = start & ~start_d_q;

    // Operand conditioning. The iteration always works on magnitudes. In the
    // signed build the signs are recorded here and applied in the fix-up cycle.
    // |most-negative| still fits as an unsigned WIDTH-bit magnitude.
`ifdef DIV_SIGNED_EN
    assign a_neg   = dividend_q[WIDTH-1];
    assign b_neg   = data_in[WIDTH-1];
    assign a_mag   = a_neg ? -dividend_q : dividend_q;
    assign b_mag   = b_neg ? -data_in : data_in;
    assign ovf_det = (dividend_q == {1'b1, {(WIDTH-1){1'b0}}}) && (data_in == '1);
`else
    assign a_neg   = 1'b0;
    assign b_neg   = 1'b0;
    assign a_mag   = dividend_q;
    assign b_mag   = data_in;
    assign ovf_det = 1'b0;
`endif

    // One non-restoring step. This shifts {P,Q} left, then subtracts D when P
    // was non-negative and adds D when it was negative. WIDTH+1 bits is enough
    // because the result always lies in [-D, D). Any wrap of the shifted
    // intermediate cancels modulo 2^(WIDTH+1).
    assign p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign p_step = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
    assign p_fix  = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_rise) state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = (data_in == '0) ? S_FIX : S_CALC;
            S_CALC:   if (count_q == '0) state_d = S_FIX;
            S_FIX:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next-state logic
    // NOTE: every *_d signal gets a default before the case statement, so no branch leaves one unassigned and no latch is inferred.
    always_comb begin
        count_d       = count_q;
        dividend_d    = dividend_q;
        d_d           = d_q;
        p_d           = p_q;
        q_d           = q_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        case (state_q)
            S_IDLE: if (start_rise) busy_d = 1'b1;
            S_LOAD_A: dividend_d = data_in;
            S_LOAD_B: begin
                d_d     = b_mag;
                q_d     = a_mag;
                p_d     = '0;
                neg_q_d = a_neg ^ b_neg;
                neg_r_d = a_neg;
                dbz_d   = (data_in == '0);
                ovf_d   = ovf_det;
                count_d = CW'(WIDTH - 1);
            end
            S_CALC: begin
                p_d = p_step;
                q_d = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                if (count_q != '0) count_d = count_q - CW'(1);
            end
            S_FIX: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (dbz_q) begin
                    quotient_d    = '1;
                    remainder_d   = dividend_q;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else begin
                    quotient_d    = neg_q_q ? -q_q : q_q;
                    remainder_d   = neg_r_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
                    div_by_zero_d = 1'b0;
                    overflow_d    = ovf_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d_q     <= 1'b0;
            count_q       <= '0;
            dividend_q    <= '0;
            d_q           <= '0;
            p_q           <= '0;
            q_q           <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            start_d_q     <= start;
            count_q       <= count_d;
            dividend_q    <= dividend_d;
            d_q           <= d_d;
            p_q           <= p_d;
            q_q           <= q_d;
            neg_q_q       <= neg_q_d;
            neg_r_q       <= neg_r_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_nr_div_seq.sv
// -----------------------------------------------------------------------------
// tb_nr_div_seq
//   Self-checking bench for nr_div_seq (WIDTH=8). It uses a table of directed
//   divisions with hand-computed results, plus sequences for start held high,
//   a start edge during CALC, and reset asserted during CALC. The expected
//   values follow the build option DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_nr_div_seq;

    localparam int W       = 8;
    localparam int LAT     = W + 1;  // negedges after E2 until done is seen
    localparam int LAT_DBZ = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;

    nr_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic [W-1:0] a, b, q, r, input logic dbz, ovf);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz; v.ovf = ovf;
        v.lat = dbz ? LAT_DBZ : LAT;
        vecs.push_back(v);
    endtask

    // Runs one operation with a single-cycle start pulse. It returns the
    // number of negedges after E2 until done is seen, or -1 if done never
    // appears within the bound. It also checks busy right after the start
    // edge and that the old quotient is still held while the new operands
    // load.
    task automatic run_op(input logic [W-1:0] a, b, input logic [W-1:0] prev_q,
                          input string tag, output int lat);
        @(negedge clk); start = 1'b1; data_in = W'($urandom);
        @(negedge clk); start = 1'b0; data_in = a;
        check({tag, " busy after start"}, busy, 1);
        @(negedge clk); data_in = b;
        @(negedge clk); data_in = W'($urandom);
        check({tag, " quotient held during load"}, quotient, prev_q);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            data_in = W'($urandom);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           pulses;
        logic [W-1:0] prev_q;
        logic [W-1:0] got_q, got_r;
        logic [W-1:0] exp_q, exp_r;

`ifdef DIV_SIGNED_EN
        add(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0);
        add(8'hF6,  8'd3,   8'hFD,  8'hFF,  1'b0, 1'b0);  // -10 / 3
        add(8'd10,  8'hFD,  8'hFD,  8'h01,  1'b0, 1'b0);  // 10 / -3
        add(8'd10,  8'd0,   8'hFF,  8'h0A,  1'b1, 1'b0);
        add(8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1);  // overflow
        add(8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0);
        add(8'hF9,  8'hFE,  8'h03,  8'hFF,  1'b0, 1'b0);  // -7 / -2
        add(8'h7F,  8'h80,  8'h00,  8'h7F,  1'b0, 1'b0);  // 127 / -128
        add(8'h00,  8'd5,   8'h00,  8'h00,  1'b0, 1'b0);
`else
        add(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0);
        add(8'd10,  8'd0,   8'hFF,  8'h0A,  1'b1, 1'b0);
        add(8'd128, 8'd255, 8'd0,   8'd128, 1'b0, 1'b0);
        add(8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b0);
        add(8'd200, 8'd9,   8'd22,  8'd2,   1'b0, 1'b0);
        add(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0);
        add(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 1'b0);
        add(8'd7,   8'd255, 8'd0,   8'd7,   1'b0, 1'b0);
        add(8'd250, 8'd250, 8'd1,   8'd0,   1'b0, 1'b0);
`endif

        // Reset state
        rst_n = 1'b0; start = 1'b0; data_in = '0;
        @(negedge clk); @(negedge clk);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy/done/dbz/ovf", {busy, done, div_by_zero, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven divisions
        prev_q = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d %0h/%0h", i, vecs[i].a, vecs[i].b);
            run_op(vecs[i].a, vecs[i].b, prev_q, tag, lat);
            check({tag, " latency"}, lat, vecs[i].lat);
            check({tag, " quotient"}, quotient, vecs[i].q);
            check({tag, " remainder"}, remainder, vecs[i].r);
            check({tag, " div_by_zero"}, div_by_zero, vecs[i].dbz);
            check({tag, " overflow"}, overflow, vecs[i].ovf);
            check({tag, " busy low at done"}, busy, 0);
            @(negedge clk);
            check({tag, " done one cycle"}, done, 0);
            check({tag, " quotient holds"}, quotient, vecs[i].q);
            prev_q = vecs[i].q;
        end

        // start held high for 40 cycles: exactly one operation
`ifdef DIV_SIGNED_EN
        exp_q = 8'hFA; exp_r = 8'hFE;  // -56 / 9
`else
        exp_q = 8'd22; exp_r = 8'd2;
`endif
        pulses = 0; got_q = '0; got_r = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); data_in = 8'd200;
        @(negedge clk); data_in = 8'd9;
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            data_in = W'($urandom);
            if (done) begin
                pulses++;
                got_q = quotient;
                got_r = remainder;
            end
        end
        start = 1'b0;
        check("held start done pulses", pulses, 1);
        check("held start quotient", got_q, exp_q);
        check("held start remainder", got_r, exp_r);

        // Second start edge during CALC is ignored
        pulses = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; data_in = 8'd100;
        @(negedge clk); data_in = 8'd7;
        @(negedge clk); data_in = W'($urandom);
        @(negedge clk); @(negedge clk);
        start = 1'b1;  // rises mid-CALC
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) pulses++;
        end
        check("mid-CALC start done pulses", pulses, 1);
        check("mid-CALC start quotient", quotient, 14);
        check("mid-CALC start remainder", remainder, 2);
        check("mid-CALC start busy idle", busy, 0);

        // Reset during CALC
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; data_in = 8'd100;
        @(negedge clk); data_in = 8'd7;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("pre-reset busy in CALC", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid-CALC reset quotient", quotient, 0);
        check("mid-CALC reset remainder", remainder, 0);
        check("mid-CALC reset busy/done/dbz/ovf", {busy, done, div_by_zero, overflow}, 0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("no activity after reset", pulses, 0);
`ifdef DIV_SIGNED_EN
        exp_q = 8'h00; exp_r = 8'hFF;  // -1 / 16
`else
        exp_q = 8'd15; exp_r = 8'd15;
`endif
        run_op(8'd255, 8'd16, 8'd0, "post-reset 255/16", lat);
        check("post-reset latency", lat, LAT);
        check("post-reset quotient", quotient, exp_q);
        check("post-reset remainder", remainder, exp_r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
